// File: rtl/onehot_decoder_pkg.sv
// Shared definitions for the one-hot decoder pipeline: buffer state
// encodings and the helper that derives the index width from n.
package onehot_decoder_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int DEFAULT_N = 6;

    // Index width needed to address 'count' positions (at least one bit).
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int DEFAULT_W = idx_width(DEFAULT_N);

endpackage

// File: rtl/onehot_decode.sv
// Combinational binary-to-one-hot decode of an encoder {z, y} pair.
// 'bad' marks an active index that falls outside the n output lanes.
module onehot_decode
    import onehot_decoder_pkg::*;
#(
    parameter int n = DEFAULT_N,
    localparam int W = idx_width(n)
) (
    input  logic         z,
    input  logic [W-1:0] y,
    output logic [n-1:0] w,
    output logic         bad
);

    // Inactive or out-of-range words decode to all zeros.
    always_comb begin
        w   = '0;
        bad = 1'b0;
        if (z) begin
            if (int'(y) < n) begin
                w = n'(1) << y;
            end else begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// One-hot decoder with valid/ready on both sides. A two-entry skid buffer
// (main + skid register) keeps in_ready registered while sustaining one
// transfer per cycle; out-of-range indices raise a sticky error.
module onehot_decoder_pipe
    import onehot_decoder_pkg::*;
#(
    parameter int n = DEFAULT_N,
    localparam int W = idx_width(n)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         z,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] w,
    output logic         err,
    input  logic         err_clr
);

    state_t       state;
    state_t       state_next;
    logic [n-1:0] main_q;
    logic [n-1:0] skid_q;
    logic [n-1:0] dec_w;
    logic         dec_bad;
    logic         accept;
    logic         pop;

    onehot_decode #(.n(n)) u_decode (
        .z   (z),
        .y   (y),
        .w   (dec_w),
        .bad (dec_bad)
    );

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign w         = main_q;

    // Occupancy after this edge, from the handshakes seen this cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (accept) state_next = ST_ONE;
            ST_ONE: begin
                if (accept && !pop) state_next = ST_TWO;
                else if (!accept && pop) state_next = ST_EMPTY;
            end
            ST_TWO: if (pop) state_next = ST_ONE;
            default: state_next = ST_EMPTY;
        endcase
    end

    // State and in_ready register; in_ready looks ahead so a full buffer never accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != ST_TWO);
        end
    end

    // Data movement: new words land in main when it frees up, else in skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (accept) main_q <= dec_w;
                ST_ONE: begin
                    if (accept && pop) main_q <= dec_w;
                    else if (accept) skid_q <= dec_w;
                end
                ST_TWO: if (pop) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    // Sticky error; a new bad word in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && dec_bad) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench for onehot_decoder_pipe (n = 6): directed vectors with
// literal expectations plus a queue-based model compared every cycle.
module tb_onehot_decoder_pipe;

    localparam int N  = 6;
    localparam int YW = $clog2(N);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          z;
    logic [YW-1:0] y;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  w;
    logic          err;
    logic          err_clr;

    int cmp_count  = 0;
    int fail_count = 0;
    bit cmp_en     = 0;

    // Model state: queue of words buffered in the DUT, predicted ready and error.
    logic [N-1:0] mq[$];
    bit           m_ready = 0;
    bit           m_err   = 0;

    onehot_decoder_pipe #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w         (w),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge, return at the next one.
    task automatic applyStimulus(input bit v, input bit zz, input int yy, input bit ordy, input bit clr);
        in_valid  = v;
        z         = zz;
        y         = YW'(yy);
        out_ready = ordy;
        err_clr   = clr;
        @(negedge clk);
    endtask

    // Model update at each rising edge (or asynchronous reset).
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_ready = 0;
                m_err   = 0;
            end else begin
                bit acc;
                bit bad;
                logic [N-1:0] word;
                acc  = in_valid && m_ready;
                bad  = z && (int'(y) >= N);
                word = (z && int'(y) < N) ? N'(1) << y : '0;
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (acc) mq.push_back(word);
                if (acc && bad) m_err = 1;
                else if (err_clr) m_err = 0;
                m_ready = (mq.size() < 2);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                checkOutput("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
                checkOutput("model_in_ready", 32'(in_ready), 32'(m_ready));
                checkOutput("model_err", 32'(err), 32'(m_err));
                if (mq.size() != 0) checkOutput("model_w", 32'(w), 32'(mq[0]));
            end
        end
    end

    initial begin
        rst = 0; in_valid = 0; z = 0; y = '0; out_ready = 0; err_clr = 0;

        // Reset: outputs go to reset values immediately, in_ready one edge after release.
        #2 rst = 1;
        cmp_en = 1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_w", 32'(w), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 0;
        #1 checkOutput("release_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 checkOutput("release_in_ready_high", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Sweep: back-to-back indices, one cycle latency, no bubbles.
        for (int i = 0; i < N; i++) begin
            applyStimulus(1, 1, i, 1, 0);
            checkOutput("sweep_w", 32'(w), 32'(6'b000001 << i));
            checkOutput("sweep_out_valid", 32'(out_valid), 32'd1);
            checkOutput("sweep_in_ready", 32'(in_ready), 32'd1);
        end
        applyStimulus(1, 0, 3, 1, 0);
        checkOutput("zero_w", 32'(w), 32'h00);
        checkOutput("zero_err", 32'(err), 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

        // Out-of-range indices and sticky error behaviour.
        applyStimulus(1, 1, 6, 1, 0);
        checkOutput("oor6_w", 32'(w), 32'h00);
        checkOutput("oor6_err", 32'(err), 32'd1);
        applyStimulus(1, 1, 7, 1, 0);
        checkOutput("oor7_w", 32'(w), 32'h00);
        checkOutput("oor7_err", 32'(err), 32'd1);
        applyStimulus(1, 1, 6, 1, 1);
        checkOutput("set_wins_err", 32'(err), 32'd1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("clr_err", 32'(err), 32'd0);

        // Backpressure: two words buffered, third held off, then in-order drain.
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("bp1_w", 32'(w), 32'h02);
        checkOutput("bp1_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1, 1, 2, 0, 0);
        checkOutput("bp2_w", 32'(w), 32'h02);
        checkOutput("bp2_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 1, 3, 0, 0);
        checkOutput("bp3_w_stable", 32'(w), 32'h02);
        checkOutput("bp3_out_valid", 32'(out_valid), 32'd1);
        applyStimulus(1, 1, 3, 1, 0);
        checkOutput("bp_drain2_w", 32'(w), 32'h04);
        checkOutput("bp_drain2_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1, 1, 3, 1, 0);
        checkOutput("bp_drain3_w", 32'(w), 32'h08);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("bp_empty", 32'(out_valid), 32'd0);

        // Reset while both entries are full: nothing stale survives.
        applyStimulus(1, 1, 4, 0, 0);
        applyStimulus(1, 1, 5, 0, 0);
        checkOutput("two_in_ready", 32'(in_ready), 32'd0);
        in_valid = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        checkOutput("rst2_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst2_w", 32'(w), 32'd0);
        checkOutput("rst2_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("post_rst_out_valid2", 32'(out_valid), 32'd0);

        // Round trip through a priority encoder: output is the highest set bit.
        for (int v = 0; v < 64; v++) begin
            bit enc_z;
            int enc_y;
            logic [N-1:0] top;
            enc_z = (v != 0);
            enc_y = 0;
            for (int b = 0; b < N; b++) if (v[b]) enc_y = b;
            top = N'(v);
            while ((top & (top - 1'b1)) != '0) top = top & (top - 1'b1);
            applyStimulus(1, enc_z, enc_y, 1, 0);
            checkOutput("roundtrip_w", 32'(w), 32'(top));
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("roundtrip_err", 32'(err), 32'd0);

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
        $finish;
    end

endmodule
